// File: rtl/campfire_checkpoint.sv
// Campfire checkpoint: lights a campfire after the player lingers nearby for
// ARM_FRAMES frames, animates its flame, and answers respawn position requests.
module campfire_checkpoint #(
  parameter int PROX_X      = 16,
  parameter int PROX_Y      = 24,
  parameter int ARM_FRAMES  = 30,
  parameter int FLICKER_DIV = 8,
  parameter int SPAWN_YOFF  = 8,
  parameter int DEFAULT_X   = 20,
  parameter int DEFAULT_Y   = 400
) (
  input  logic        sim_clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [31:0] campfireState,
  input  logic [31:0] playerState,
  input  logic        extinguish,
  input  logic        respawn_req,
  output logic        respawn_valid,
  output logic [31:0] respawnState,
  output logic        lit,
  output logic        lit_pulse,
  output logic [1:0]  flame_frame,
  output logic [7:0]  arm_count
);

  typedef enum logic [1:0] {UNLIT, ARMING, LIT} state_t;

  localparam logic [10:0] ProxX11   = 11'(PROX_X);
  localparam logic [10:0] ProxY11   = 11'(PROX_Y);
  localparam logic [7:0]  ArmTarget = 8'(ARM_FRAMES);
  localparam logic [7:0]  DivLast   = 8'(FLICKER_DIV - 1);
  localparam logic [9:0]  YOff10    = 10'(SPAWN_YOFF);
  localparam logic [31:0] DefaultSpawn = {10'(DEFAULT_X), 10'(DEFAULT_Y), 12'h000};

  state_t      state_q;
  logic [7:0]  armCount_q;
  logic [7:0]  armCount_d;
  logic [7:0]  divCount_q;
  logic [1:0]  flameFrame_q;
  logic        litPulse_q;
  logic        respawnValid_q;
  logic [31:0] respawnState_q;

  logic [9:0]  cx, cy, px, py;
  logic [10:0] dx, dy, absDx, absDy;
  logic [9:0]  spawnY;
  logic        near;
  logic        unusedBits;

  assign cx = campfireState[31:22];
  assign cy = campfireState[21:12];
  assign px = playerState[31:22];
  assign py = playerState[21:12];
  assign unusedBits = ^{campfireState[11:0], playerState[11:0]};

  // Zero-extended 11-bit differences cannot wrap; bit 10 is the sign.
  assign dx    = {1'b0, px} - {1'b0, cx};
  assign dy    = {1'b0, py} - {1'b0, cy};
  assign absDx = dx[10] ? (11'd0 - dx) : dx;
  assign absDy = dy[10] ? (11'd0 - dy) : dy;
  assign near  = (absDx <= ProxX11) && (absDy <= ProxY11);

  assign spawnY     = (cy >= YOff10) ? (cy - YOff10) : 10'd0;
  assign armCount_d = armCount_q + 8'd1;

  always_ff @(posedge sim_clk) begin
    if (!reset) begin
      state_q        <= UNLIT;
      armCount_q     <= 8'd0;
      divCount_q     <= 8'd0;
      flameFrame_q   <= 2'd0;
      litPulse_q     <= 1'b0;
      respawnValid_q <= 1'b0;
      respawnState_q <= DefaultSpawn;
    end else begin
      litPulse_q     <= 1'b0;
      respawnValid_q <= respawn_req;
      // The respawn source is the state before this edge's transition.
      if (respawn_req) begin
        respawnState_q <= (state_q == LIT) ? {cx, spawnY, 12'h000} : DefaultSpawn;
      end

      if (extinguish) begin
        state_q      <= UNLIT;
        armCount_q   <= 8'd0;
        divCount_q   <= 8'd0;
        flameFrame_q <= 2'd0;
      end else begin
        case (state_q)
          UNLIT: begin
            if (frame_tick && near) begin
              armCount_q <= 8'd1;
              if (ArmTarget == 8'd1) begin
                state_q    <= LIT;
                litPulse_q <= 1'b1;
              end else begin
                state_q <= ARMING;
              end
            end else begin
              armCount_q <= 8'd0;
            end
          end
          ARMING: begin
            if (frame_tick) begin
              if (near) begin
                armCount_q <= armCount_d;
                if (armCount_d == ArmTarget) begin
                  state_q    <= LIT;
                  litPulse_q <= 1'b1;
                end
              end else begin
                state_q    <= UNLIT;
                armCount_q <= 8'd0;
              end
            end
          end
          LIT: begin
            if (frame_tick) begin
              if (divCount_q == DivLast) begin
                divCount_q   <= 8'd0;
                flameFrame_q <= flameFrame_q + 2'd1;
              end else begin
                divCount_q <= divCount_q + 8'd1;
              end
            end
          end
          default: begin
            state_q    <= UNLIT;
            armCount_q <= 8'd0;
          end
        endcase
      end
    end
  end

  assign lit           = (state_q == LIT);
  assign lit_pulse     = litPulse_q;
  assign flame_frame   = flameFrame_q;
  assign arm_count     = armCount_q;
  assign respawn_valid = respawnValid_q;
  assign respawnState  = respawnState_q;

endmodule

// File: tb/tb_campfire_checkpoint.sv
// Scoreboard bench for campfire_checkpoint: respawn responses are queued at
// request time and checked by an independent monitor; state outputs are checked inline.
module tb_campfire_checkpoint;

  logic        sim_clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        extinguish;
  logic        respawn_req;
  logic [31:0] campfireState;
  logic [31:0] playerState;
  logic        respawn_valid;
  logic [31:0] respawnState;
  logic        lit;
  logic        lit_pulse;
  logic [1:0]  flame_frame;
  logic [7:0]  arm_count;

  logic [9:0]  cfX, cfY, plX, plY;
  logic        modelLit;
  logic [31:0] expQ[$];
  int          assertCount = 0;
  int          failCount   = 0;

  localparam logic [31:0] DefaultSpawn = {10'd20, 10'd400, 12'h000};

  assign campfireState = {cfX, cfY, 12'h000};
  assign playerState   = {plX, plY, 12'hABC};

  always #5 sim_clk = ~sim_clk;

  campfire_checkpoint dut (
    .sim_clk       (sim_clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .campfireState (campfireState),
    .playerState   (playerState),
    .extinguish    (extinguish),
    .respawn_req   (respawn_req),
    .respawn_valid (respawn_valid),
    .respawnState  (respawnState),
    .lit           (lit),
    .lit_pulse     (lit_pulse),
    .flame_frame   (flame_frame),
    .arm_count     (arm_count)
  );

  function automatic logic [31:0] expectedSpawn();
    logic [9:0] y;
    y = (cfY >= 10'd8) ? (cfY - 10'd8) : 10'd0;
    return modelLit ? {cfX, y, 12'h000} : DefaultSpawn;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One clock: drive at the falling edge, let the rising edge sample, settle.
  task automatic applyStimulus(input logic tick, input logic req, input logic ext);
    @(negedge sim_clk);
    frame_tick  = tick;
    respawn_req = req;
    extinguish  = ext;
    if (req && reset) expQ.push_back(expectedSpawn());
    @(posedge sim_clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " arm_count"}, 32'(arm_count), 32'd0);
    checkOutput({tag, " lit"}, 32'(lit), 32'd0);
    checkOutput({tag, " lit_pulse"}, 32'(lit_pulse), 32'd0);
    checkOutput({tag, " flame_frame"}, 32'(flame_frame), 32'd0);
    checkOutput({tag, " respawn_valid"}, 32'(respawn_valid), 32'd0);
    checkOutput({tag, " respawnState"}, respawnState, DefaultSpawn);
  endtask

  // Monitor: every presented response must match the oldest queued expectation.
  always @(negedge sim_clk) begin
    if (respawn_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL respawn_unexpected: got valid with 0x%08h, expected no response", respawnState);
      end else begin
        checkOutput("respawnState", respawnState, expQ.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; frame_tick = 1'b0; extinguish = 1'b0; respawn_req = 1'b0;
    cfX = 10'd250; cfY = 10'd180; plX = 10'd600; plY = 10'd600;
    modelLit = 1'b0;
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    checkResetOutputs("reset");
    reset = 1'b1;

    $display("[TB] unlit respawn request");
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);

    $display("[TB] arming for 30 frames");
    plX = 10'd260; plY = 10'd190;
    for (int i = 1; i <= 30; i++) begin
      applyStimulus(1, 0, 0);
      checkOutput($sformatf("arm_count[%0d]", i), 32'(arm_count), 32'(i));
      checkOutput($sformatf("lit_pulse[%0d]", i), 32'(lit_pulse), 32'(i == 30));
      checkOutput($sformatf("lit[%0d]", i), 32'(lit), 32'(i == 30));
    end
    modelLit = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("lit_hold", 32'(lit), 32'd1);
    checkOutput("lit_pulse_once", 32'(lit_pulse), 32'd0);
    checkOutput("arm_count_lit", 32'(arm_count), 32'd30);

    $display("[TB] lit respawn request");
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);

    $display("[TB] flame animation over 40 frames");
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(1, 0, 0);
      checkOutput($sformatf("flame_frame[%0d]", i), 32'(flame_frame), 32'((i / 8) % 4));
    end
    checkOutput("arm_count_sticky", 32'(arm_count), 32'd30);

    $display("[TB] campfire moves while lit, clamped y");
    cfX = 10'd100; cfY = 10'd4;
    applyStimulus(1, 1, 0);
    checkOutput("lit_after_move", 32'(lit), 32'd1);
    applyStimulus(0, 0, 0);

    $display("[TB] extinguish with tick");
    applyStimulus(1, 0, 1);
    modelLit = 1'b0;
    checkOutput("ext lit", 32'(lit), 32'd0);
    checkOutput("ext flame_frame", 32'(flame_frame), 32'd0);
    checkOutput("ext arm_count", 32'(arm_count), 32'd0);

    $display("[TB] boundary proximity and break-off");
    cfX = 10'd250; cfY = 10'd180; plX = 10'd266; plY = 10'd204;
    for (int i = 1; i <= 10; i++) applyStimulus(1, 0, 0);
    checkOutput("edge_pos arm_count", 32'(arm_count), 32'd10);
    applyStimulus(0, 0, 0);
    checkOutput("no_tick hold", 32'(arm_count), 32'd10);
    plX = 10'd300; plY = 10'd180;
    applyStimulus(1, 0, 0);
    checkOutput("far arm_count", 32'(arm_count), 32'd0);
    checkOutput("far lit", 32'(lit), 32'd0);
    checkOutput("far lit_pulse", 32'(lit_pulse), 32'd0);
    plX = 10'd234; plY = 10'd156;
    applyStimulus(1, 0, 0);
    checkOutput("edge_neg arm_count", 32'(arm_count), 32'd1);
    plX = 10'd233;
    applyStimulus(1, 0, 0);
    checkOutput("outside_neg arm_count", 32'(arm_count), 32'd0);

    $display("[TB] lit campfire respawn, then reset mid-arming");
    plX = 10'd260; plY = 10'd190;
    for (int i = 1; i <= 30; i++) applyStimulus(1, 0, 0);
    modelLit = 1'b1;
    applyStimulus(0, 1, 0);
    applyStimulus(1, 0, 1);
    modelLit = 1'b0;
    for (int i = 1; i <= 12; i++) applyStimulus(1, 0, 0);
    checkOutput("arm_count_12", 32'(arm_count), 32'd12);
    reset = 1'b0;
    applyStimulus(1, 1, 0);
    checkResetOutputs("mid_arm_reset");
    reset = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("cancelled valid", 32'(respawn_valid), 32'd0);

    $display("[TB] respawn request on the lighting edge");
    for (int i = 1; i <= 29; i++) applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    checkOutput("edge lit", 32'(lit), 32'd1);
    modelLit = 1'b1;
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);

    checkOutput("responses outstanding", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
